// File: rtl/hb_cmd_issuer.sv
// Command issuer: buffers {op, val, rep} commands in a FIFO and replays each one
// as registered inc/dec/acc_clr strobes, rep+1 times, with hold and sync clear.
module hb_cmd_issuer #(
   parameter int DEPTH     = 4,
   parameter int REP_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [7:0]             cmd_val,
   input  logic [REP_WIDTH-1:0]   cmd_rep,
   input  logic                   hold,
   output logic                   inc,
   output logic [7:0]             incVal,
   output logic                   dec,
   output logic [7:0]             decVal,
   output logic                   acc_clr,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      OP_INC = 2'b00,
      OP_DEC = 2'b01,
      OP_CLR = 2'b10,
      OP_NOP = 2'b11
   } op_e;

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } state_e;

   typedef struct packed {
      op_e                  op;
      logic [7:0]           val;
      logic [REP_WIDTH-1:0] rep;
   } cmd_t;

   typedef struct packed {
      logic       inc;
      logic [7:0] inc_val;
      logic       dec;
      logic [7:0] dec_val;
      logic       acc_clr;
   } strobe_t;

   // Values are forced to zero whenever their strobe is low.
   function automatic strobe_t decode(op_e op, logic [7:0] val);
      strobe_t s;
      s = '0;
      case (op)
         OP_INC:  begin s.inc = 1'b1; s.inc_val = val; end
         OP_DEC:  begin s.dec = 1'b1; s.dec_val = val; end
         OP_CLR:  s.acc_clr = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

   cmd_t                 mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        count;
   logic                 full, empty, push, pop, load;
   cmd_t                 head, wr_cmd;

   state_e               state, state_nxt;
   logic [REP_WIDTH-1:0] remaining, rem_nxt;
   op_e                  cur_op, cur_op_nxt;
   logic [7:0]           cur_val, cur_val_nxt;
   strobe_t              strb, strb_nxt;

   assign full   = (count == LW'(DEPTH));
   assign empty  = (count == '0);
   assign push   = cmd_valid && !full;
   assign head   = mem[rd_ptr];
   assign wr_cmd = '{op: op_e'(cmd_op), val: cmd_val, rep: cmd_rep};

   // NOTE: FIFO storage has no reset; the pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= wr_cmd;
   end

   // NOTE: every next-state signal gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      rem_nxt     = remaining;
      cur_op_nxt  = cur_op;
      cur_val_nxt = cur_val;
      strb_nxt    = '0;
      load        = 1'b0;
      pop         = 1'b0;

      // hold keeps every default: state, counter and FIFO head frozen, strobes low.
      if (!hold) begin
         case (state)
            S_IDLE: begin
               if (!empty) load = 1'b1;
            end
            S_ISSUE: begin
               if (remaining != '0) begin
                  rem_nxt  = remaining - REP_WIDTH'(1);
                  strb_nxt = decode(cur_op, cur_val);
               end else if (!empty) begin
                  load = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase

         if (load) begin
            pop         = 1'b1;
            state_nxt   = S_ISSUE;
            cur_op_nxt  = head.op;
            cur_val_nxt = head.val;
            rem_nxt     = (head.op == OP_INC || head.op == OP_DEC) ? head.rep : '0;
            strb_nxt    = decode(head.op, head.val);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_IDLE;
         remaining <= '0;
         cur_op    <= OP_NOP;
         cur_val   <= '0;
         strb      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= rem_nxt;
         cur_op    <= cur_op_nxt;
         cur_val   <= cur_val_nxt;
         strb      <= strb_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(push) - LW'(pop);
      end
   end

   assign cmd_ready = !full;
   assign level     = count;
   assign busy      = (state == S_ISSUE) || (count != '0);
   assign inc       = strb.inc;
   assign incVal    = strb.inc_val;
   assign dec       = strb.dec;
   assign decVal    = strb.dec_val;
   assign acc_clr   = strb.acc_clr;

endmodule

// File: tb/tb_hb_cmd_issuer.sv
// Self-checking bench for hb_cmd_issuer: directed scenarios plus random traffic,
// compared every cycle against a slot-queue reference model.
module tb_hb_cmd_issuer;

   localparam int DEPTH     = 4;
   localparam int REP_WIDTH = 4;

   logic                 clk = 1'b0;
   logic                 clr, cmd_valid, cmd_ready, hold;
   logic [1:0]           cmd_op;
   logic [7:0]           cmd_val;
   logic [REP_WIDTH-1:0] cmd_rep;
   logic                 inc, dec, acc_clr, busy;
   logic [7:0]           incVal, decVal;
   logic [$clog2(DEPTH):0] level;

   always #5 clk = ~clk;

   hb_cmd_issuer #(.DEPTH(DEPTH), .REP_WIDTH(REP_WIDTH)) dut (
      .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_val(cmd_val), .cmd_rep(cmd_rep), .hold(hold),
      .inc(inc), .incVal(incVal), .dec(dec), .decVal(decVal),
      .acc_clr(acc_clr), .busy(busy), .level(level)
   );

   typedef struct {
      logic [1:0] op;
      logic [7:0] val;
      int         rep;
   } cmd_t;

   typedef struct packed {
      logic       inc;
      logic [7:0] incv;
      logic       dec;
      logic [7:0] decv;
      logic       clr;
   } slot_t;

   // Model: queued commands, plus the per-cycle output slots of the command in flight.
   cmd_t  fifo_q[$];
   slot_t slot_q[$];
   slot_t out_m;
   bit    active;

   int checks   = 0;
   int failures = 0;
   int n_inc, n_dec, n_clr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic expand(input cmd_t c);
      slot_t s;
      s = '0;
      case (c.op)
         2'b00: begin s.inc = 1'b1; s.incv = c.val; for (int i = 0; i <= c.rep; i++) slot_q.push_back(s); end
         2'b01: begin s.dec = 1'b1; s.decv = c.val; for (int i = 0; i <= c.rep; i++) slot_q.push_back(s); end
         2'b10: begin s.clr = 1'b1; slot_q.push_back(s); end
         default: slot_q.push_back(s);
      endcase
   endtask

   task automatic model_edge();
      bit   do_push;
      cmd_t c;
      if (clr) begin
         fifo_q.delete();
         slot_q.delete();
         active = 1'b0;
         out_m  = '0;
         return;
      end
      do_push = cmd_valid && (fifo_q.size() < DEPTH);
      if (hold) begin
         out_m = '0;
      end else begin
         if (slot_q.size() == 0 && fifo_q.size() != 0) begin
            c = fifo_q.pop_front();
            expand(c);
         end
         if (slot_q.size() != 0) begin
            out_m  = slot_q.pop_front();
            active = 1'b1;
         end else begin
            out_m  = '0;
            active = 1'b0;
         end
      end
      if (do_push) begin
         c.op = cmd_op; c.val = cmd_val; c.rep = int'(cmd_rep);
         fifo_q.push_back(c);
      end
   endtask

   task automatic compare();
      check("inc",        inc,     out_m.inc);
      check("incVal",     incVal,  out_m.incv);
      check("dec",        dec,     out_m.dec);
      check("decVal",     decVal,  out_m.decv);
      check("acc_clr",    acc_clr, out_m.clr);
      check("level",      level,   fifo_q.size());
      check("busy",       busy,    active || (fifo_q.size() != 0));
      check("cmd_ready",  cmd_ready, fifo_q.size() < DEPTH);
      check("one_strobe", (int'(inc) + int'(dec) + int'(acc_clr)) <= 1, 1'b1);
   endtask

   task automatic step(input logic v, input logic [1:0] op, input logic [7:0] val,
                       input logic [REP_WIDTH-1:0] rep, input logic h, input logic c);
      cmd_valid = v; cmd_op = op; cmd_val = val; cmd_rep = rep; hold = h; clr = c;
      @(posedge clk);
      model_edge();
      #1;
      compare();
      n_inc += int'(inc);
      n_dec += int'(dec);
      n_clr += int'(acc_clr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b11, 8'h00, '0, 1'b0, 1'b0);
   endtask

   task automatic zero_counts();
      n_inc = 0; n_dec = 0; n_clr = 0;
   endtask

   initial begin
      logic [1:0]           r_op;
      logic [7:0]           r_val;
      logic [REP_WIDTH-1:0] r_rep;
      active = 1'b0;
      out_m  = '0;
      zero_counts();

      // Reset, including a command offered while clr is high.
      step(1'b0, 2'b00, 8'h00, '0, 1'b0, 1'b1);
      step(1'b1, 2'b00, 8'h07, '0, 1'b0, 1'b1);
      idle(2);

      // Single command: inc 5, rep 2.
      zero_counts();
      step(1'b1, 2'b00, 8'h05, 4'd2, 1'b0, 1'b0);
      idle(5);
      check("single_inc_count", n_inc, 3);
      check("single_busy_end", busy, 1'b0);

      // Back-to-back: inc 3 rep 0, dec 0x80 rep 1, clear (rep ignored).
      zero_counts();
      step(1'b1, 2'b00, 8'h03, 4'd0, 1'b0, 1'b0);
      step(1'b1, 2'b01, 8'h80, 4'd1, 1'b0, 1'b0);
      step(1'b1, 2'b10, 8'h44, 4'd5, 1'b0, 1'b0);
      idle(6);
      check("b2b_inc_count", n_inc, 1);
      check("b2b_dec_count", n_dec, 2);
      check("b2b_clr_count", n_clr, 1);

      // Full FIFO under hold; fifth push refused; then drain.
      zero_counts();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b00, 8'(i + 1), 4'd1, 1'b1, 1'b0);
      check("full_level", level, DEPTH);
      check("full_ready", cmd_ready, 1'b0);
      step(1'b1, 2'b01, 8'h55, 4'd0, 1'b1, 1'b0);
      check("full_level_after_5th", level, DEPTH);
      idle(12);
      check("full_inc_count", n_inc, 2 * DEPTH);
      check("full_dec_count", n_dec, 0);

      // Hold for two cycles after the second strobe of an inc rep 3.
      zero_counts();
      step(1'b1, 2'b00, 8'h09, 4'd3, 1'b0, 1'b0);
      idle(2);
      check("hold_before", n_inc, 2);
      step(1'b0, 2'b11, 8'h00, '0, 1'b1, 1'b0);
      step(1'b0, 2'b11, 8'h00, '0, 1'b1, 1'b0);
      check("hold_frozen", n_inc, 2);
      idle(5);
      check("hold_inc_total", n_inc, 4);

      // Clear during a rep 15 issue with three commands queued.
      step(1'b1, 2'b00, 8'h11, 4'd15, 1'b0, 1'b0);
      step(1'b1, 2'b01, 8'h22, 4'd2, 1'b0, 1'b0);
      step(1'b1, 2'b00, 8'h33, 4'd1, 1'b0, 1'b0);
      step(1'b1, 2'b10, 8'h00, 4'd0, 1'b0, 1'b0);
      idle(2);
      check("pre_reset_level", level, 3);
      step(1'b0, 2'b11, 8'h00, '0, 1'b0, 1'b1);
      check("reset_busy", busy, 1'b0);
      zero_counts();
      idle(20);
      check("after_reset_strobes", n_inc + n_dec + n_clr, 0);

      // No-op followed by max repeat.
      zero_counts();
      step(1'b1, 2'b11, 8'h99, 4'd7, 1'b0, 1'b0);
      step(1'b1, 2'b00, 8'h7f, 4'd15, 1'b0, 1'b0);
      check("nop_no_strobe", n_inc + n_dec + n_clr, 0);
      idle(20);
      check("maxrep_inc_count", n_inc, 16);

      // Random traffic with occasional hold and clear.
      for (int i = 0; i < 400; i++) begin
         r_op  = 2'($urandom);
         r_val = 8'($urandom);
         r_rep = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
         step(1'($urandom_range(0, 1)), r_op, r_val, r_rep,
              $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
      end
      idle(70);
      check("drain_idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
